// File: rtl/entrada_botoes_pontos_if.sv
// Button-conditioning bus: raw buttons in, qualified point events and debounced state out.
interface entrada_botoes_pontos_if;
  logic [2:0] b_raw;
  logic       pulso;
  logic [1:0] pontos;
  logic       erro;
  logic       ocupado;
  logic [2:0] estavel;

  modport slave (
    input  b_raw,
    output pulso, pontos, erro, ocupado, estavel
  );

  modport master (
    output b_raw,
    input  pulso, pontos, erro, ocupado, estavel
  );
endinterface

// File: rtl/entrada_botoes_pontos.sv
// Synchronize, debounce and qualify the three point buttons into one event per press.
// Optional macro AUTO_REPEAT_EN: re-issue pulso every REPEAT_CYCLES while a single button stays held.
module entrada_botoes_pontos #(
  parameter int DEB_CYCLES    = 3,
  parameter int SETTLE_CYCLES = 2,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_CYCLES = 60
) (
  input  logic                    clock,
  input  logic                    clr,
  entrada_botoes_pontos_if.slave  bus
);

  localparam int MAX_DS = (DEB_CYCLES > SETTLE_CYCLES) ? DEB_CYCLES : SETTLE_CYCLES;
  localparam int MAX_C  = (MAX_DS > REPEAT_CYCLES) ? MAX_DS : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT_REL} state_t;

  logic [2:0]    w_pol;
  logic [2:0]    r_sync1, r_sync2, r_estavel;
  logic [CW-1:0] r_deb_cnt [3];

  state_t        r_state, w_state_next;
  logic [2:0]    r_mask, w_mask_next, w_mask_or;
  logic [CW-1:0] r_set_cnt, w_set_cnt_next;
  logic          r_pulso, w_pulso_next;
  logic          r_erro, w_erro_next;
  logic [1:0]    r_pontos, w_pontos_next;
  logic          w_onehot;

`ifdef AUTO_REPEAT_EN
  logic [CW-1:0] r_rep_cnt, w_rep_cnt_next;
  logic          r_rep_on, w_rep_on_next;
`endif

  assign w_pol = (ACTIVE_LOW != 0) ? ~bus.b_raw : bus.b_raw;

  always_ff @(posedge clock) begin
    if (clr) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_estavel <= '0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_pol;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_estavel[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_estavel[i] <= ~r_estavel[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + ONE;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_set_cnt <= '0;
      r_pulso   <= 1'b0;
      r_erro    <= 1'b0;
      r_pontos  <= '0;
`ifdef AUTO_REPEAT_EN
      r_rep_cnt <= '0;
      r_rep_on  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_mask    <= w_mask_next;
      r_set_cnt <= w_set_cnt_next;
      r_pulso   <= w_pulso_next;
      r_erro    <= w_erro_next;
      r_pontos  <= w_pontos_next;
`ifdef AUTO_REPEAT_EN
      r_rep_cnt <= w_rep_cnt_next;
      r_rep_on  <= w_rep_on_next;
`endif
    end
  end

  // The final settle sample is OR-ed in before the mask is judged.
  assign w_mask_or = r_mask | r_estavel;
  assign w_onehot  = (w_mask_or == 3'b001) || (w_mask_or == 3'b010) || (w_mask_or == 3'b100);

  always_comb begin
    w_state_next   = r_state;
    w_mask_next    = r_mask;
    w_set_cnt_next = r_set_cnt;
    w_pulso_next   = 1'b0;
    w_erro_next    = 1'b0;
    w_pontos_next  = r_pontos;
`ifdef AUTO_REPEAT_EN
    w_rep_cnt_next = r_rep_cnt;
    w_rep_on_next  = r_rep_on;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_estavel != 3'b000) begin
          w_state_next   = S_SETTLE;
          w_mask_next    = r_estavel;
          w_set_cnt_next = ONE;
        end
      end
      S_SETTLE: begin
        w_mask_next = w_mask_or;
        if (r_set_cnt == SET_LAST) begin
          w_state_next = S_WAIT_REL;
          if (w_onehot) begin
            w_pulso_next  = 1'b1;
            w_pontos_next = w_mask_or[0] ? 2'd1 : (w_mask_or[1] ? 2'd2 : 2'd3);
`ifdef AUTO_REPEAT_EN
            w_rep_on_next  = 1'b1;
            w_rep_cnt_next = ONE;
`endif
          end else begin
            w_erro_next = 1'b1;
`ifdef AUTO_REPEAT_EN
            w_rep_on_next = 1'b0;
`endif
          end
        end else begin
          w_set_cnt_next = r_set_cnt + ONE;
        end
      end
      S_WAIT_REL: begin
        if (r_estavel == 3'b000) w_state_next = S_IDLE;
`ifdef AUTO_REPEAT_EN
        // Any deviation from the held single button ends repeating for this press.
        if (r_rep_on) begin
          if (r_estavel != r_mask) begin
            w_rep_on_next = 1'b0;
          end else if (r_rep_cnt == CW'(REPEAT_CYCLES)) begin
            w_pulso_next   = 1'b1;
            w_rep_cnt_next = ONE;
          end else begin
            w_rep_cnt_next = r_rep_cnt + ONE;
          end
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.pulso   = r_pulso;
  assign bus.erro    = r_erro;
  assign bus.pontos  = r_pontos;
  assign bus.estavel = r_estavel;
  assign bus.ocupado = (r_state != S_IDLE);

endmodule

// File: tb/tb_entrada_botoes_pontos.sv
// Directed bench for entrada_botoes_pontos (DEB=4, SETTLE=3, active-low buttons, REPEAT=10).
module tb_entrada_botoes_pontos;

  logic clock = 1'b0;
  logic clr   = 1'b1;
  entrada_botoes_pontos_if bus ();

  entrada_botoes_pontos #(
    .DEB_CYCLES(4), .SETTLE_CYCLES(3), .ACTIVE_LOW(1), .REPEAT_CYCLES(10)
  ) dut (
    .clock(clock),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [2:0] first;
    logic [2:0] second;
    int         delay;
    int         hold;
    int         exp_pulsos;
    int         exp_erros;
    logic [1:0] exp_pontos;
    logic [2:0] exp_seen;
  } vec_t;

  vec_t vecs [8];

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_pulso  = 0;
  int         n_erro   = 0;
  int         n_both   = 0;
  logic [2:0] seen_est = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (bus.pulso === 1'b1) n_pulso++;
      if (bus.erro === 1'b1) n_erro++;
      if (bus.pulso === 1'b1 && bus.erro === 1'b1) n_both++;
      seen_est = seen_est | bus.estavel;
    end
  endtask

  task automatic press(input logic [2:0] m);
    bus.b_raw = ~m;
  endtask

  initial begin
    int base_p, base_e, exp_rep;

    vecs[0] = '{"glitch3",      3'b001, 3'b000, 0, 3,  0, 0, 2'd2, 3'b000};
    vecs[1] = '{"b0_b2_d2",     3'b001, 3'b100, 2, 12, 0, 1, 2'd2, 3'b101};
    vecs[2] = '{"b0_b2_d5",     3'b001, 3'b100, 5, 12, 1, 0, 2'd1, 3'b101};
    vecs[3] = '{"b2_single",    3'b100, 3'b000, 0, 12, 1, 0, 2'd3, 3'b100};
    vecs[4] = '{"b0b1_simul",   3'b011, 3'b000, 0, 12, 0, 1, 2'd3, 3'b011};
    vecs[5] = '{"b1_single",    3'b010, 3'b000, 0, 12, 1, 0, 2'd2, 3'b010};
    vecs[6] = '{"all_three",    3'b111, 3'b000, 0, 12, 0, 1, 2'd2, 3'b111};
    vecs[7] = '{"b2_short4",    3'b100, 3'b000, 0, 4,  1, 0, 2'd3, 3'b100};

    // Reset with all buttons released (raw high).
    bus.b_raw = 3'b111;
    clr = 1'b1;
    tick(2);
    chk("rst_pulso",   bus.pulso,   0);
    chk("rst_erro",    bus.erro,    0);
    chk("rst_pontos",  bus.pontos,  0);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_estavel", bus.estavel, 0);
    clr = 1'b0;
    base_p = n_pulso; base_e = n_erro;
    tick(100);
    chk("idle_pulsos",  n_pulso - base_p, 0);
    chk("idle_erros",   n_erro - base_e,  0);
    chk("idle_ocupado", bus.ocupado,      0);

    // Exact latency: bit1 pressed before edge k.
    press(3'b010);
    base_p = n_pulso;
    tick(5);
    chk("lat_est_k4", bus.estavel, 3'b000);
    tick(1);
    chk("lat_est_k5", bus.estavel, 3'b010);
    tick(3);
    chk("lat_pulso_k8", bus.pulso, 0);
    tick(1);
    chk("lat_pulso_k9",  bus.pulso,  1);
    chk("lat_pontos_k9", bus.pontos, 2);
    tick(1);
    chk("lat_pulso_k10",   bus.pulso,   0);
    chk("lat_ocupado_k10", bus.ocupado, 1);
    tick(9);
    press(3'b000);
    tick(6);
    chk("rel_est_r5",     bus.estavel, 3'b000);
    chk("rel_ocupado_r5", bus.ocupado, 1);
    tick(1);
    chk("rel_ocupado_r6", bus.ocupado, 0);
    tick(10);

    foreach (vecs[v]) begin
      base_p   = n_pulso;
      base_e   = n_erro;
      seen_est = '0;
      press(vecs[v].first);
      if (vecs[v].second != 3'b000) begin
        tick(vecs[v].delay);
        press(vecs[v].first | vecs[v].second);
        tick(vecs[v].hold - vecs[v].delay);
      end else begin
        tick(vecs[v].hold);
      end
      press(3'b000);
      tick(30);
      chk({vecs[v].name, "_pulsos"}, n_pulso - base_p, vecs[v].exp_pulsos);
      chk({vecs[v].name, "_erros"},  n_erro - base_e,  vecs[v].exp_erros);
      chk({vecs[v].name, "_pontos"}, bus.pontos,       vecs[v].exp_pontos);
      chk({vecs[v].name, "_seen"},   seen_est,         vecs[v].exp_seen);
    end

    // clr two cycles into SETTLE aborts the event; held button re-qualifies afterwards.
    base_p = n_pulso;
    press(3'b100);
    tick(8);
    chk("mid_ocupado_pre", bus.ocupado, 1);
    clr = 1'b1;
    tick(2);
    chk("mid_pulsos_clr", n_pulso - base_p, 0);
    chk("mid_pontos_clr", bus.pontos,       0);
    chk("mid_est_clr",    bus.estavel,      0);
    chk("mid_ocup_clr",   bus.ocupado,      0);
    clr = 1'b0;
    tick(9);
    chk("mid_pulso_c8", bus.pulso, 0);
    tick(1);
    chk("mid_pulso_c9",  bus.pulso,  1);
    chk("mid_pontos_c9", bus.pontos, 3);
    chk("mid_pulsos_tot", n_pulso - base_p, 1);
    press(3'b000);
    tick(30);

    // Long hold of bit0: repeats only when the feature is built in.
    base_p = n_pulso;
    press(3'b001);
    tick(40);
    press(3'b000);
    tick(30);
`ifdef AUTO_REPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    chk("rep_pulsos", n_pulso - base_p, exp_rep);
    chk("rep_pontos", bus.pontos,       1);

    chk("pulso_erro_excl", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/entrada_botoes_pontos.md
Name: entrada_botoes_pontos

Overview:
Input conditioning stage directly upstream of the 2-bit point-value decoder that feeds placarTimes. Synchronizes and debounces the three raw point pushbuttons b[2:0] and collects near-simultaneous presses in a short settle window. It then emits exactly one qualified event per press: pontos 1/2/3 with a one-cycle pulso, or an erro pulse for multi-button presses. Runs in the placar clock domain (clks[0], 120 Hz), so placar adds once per physical press.

Parameters:
DEB_CYCLES, 3, consecutive clock edges a synchronized input must differ from its debounced value before the debounced value flips (min 1)
SETTLE_CYCLES, 2, cycles the press mask is accumulated after first debounced press (min 1)
ACTIVE_LOW, 1, 1 = raw buttons pressed when 0 (board pushbuttons); 0 = pressed when 1
REPEAT_CYCLES, 60, auto-repeat period in cycles; only used with AUTO_REPEAT_EN

Ports:
clock  in  1  block clock (clks[0])
clr  in  1  synchronous active-high reset
b_raw  in  3  raw asynchronous pushbuttons; bit i = "i+1 points"
pulso  out  1  one-cycle strobe qualifying pontos
pontos  out  2  point value 1..3; held until next pulso
erro  out  1  one-cycle strobe: more than one button in the settle window
ocupado  out  1  high whenever FSM is not IDLE
estavel  out  3  debounced, polarity-corrected button state (1 = pressed)

Behaviour:
- Reset (clr high at an edge): synchronizer flops, debounce counters, mask, and FSM clear. pulso=0, erro=0, pontos=0, ocupado=0, estavel=0. Synchronizer reset value = "not pressed" after polarity.
- Polarity: p = ACTIVE_LOW ? ~b_raw : b_raw, passed through a 2-flop synchronizer per bit.
- Debounce, per bit, independent: if sync bit != estavel bit, counter++. When the counter would reach DEB_CYCLES, estavel bit flips and the counter clears. If sync bit == estavel bit, the counter clears. A glitch shorter than DEB_CYCLES edges never changes estavel.
- Latency: raw change present before edge k appears on estavel after edge k+1+DEB_CYCLES.
- FSM states IDLE, SETTLE, WAIT_REL:
  - IDLE: if estavel!=0, go to SETTLE and load mask=estavel, settle counter=1.
  - SETTLE: mask|=estavel each cycle. After SETTLE_CYCLES cycles in SETTLE, evaluate mask and go to WAIT_REL.
    - Exactly one bit i set: pulso=1 for one cycle, pontos=i+1.
    - Two or more bits set: erro=1 for one cycle, pontos unchanged.
    - Buttons released during SETTLE still count; mask is sticky.
  - WAIT_REL: stay until estavel==0, then go to IDLE the next edge. Further presses while here produce no event.
- pulso visible in the cycle after edge k+DEB_CYCLES+SETTLE_CYCLES+2 (k as above). pulso and erro are never high together.
- pontos is never 0 after the first event.
- Counter widths: $clog2 of max(DEB_CYCLES, SETTLE_CYCLES, REPEAT_CYCLES)+1. No wrap-around possible.
- Reset mid-operation aborts any pending event; no pulse is generated. A button still held when clr drops re-debounces from estavel=0 and yields a fresh event.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in WAIT_REL with a single-bit mask, if estavel==mask is held continuously, pulso re-asserts (same pontos) every REPEAT_CYCLES cycles, counted from the original pulso. Any change in estavel stops the repeat.
- erro events never repeat.
- Undefined: exactly one event per press; REPEAT_CYCLES is unused and no repeat counter is synthesized.

Test Plan:
All tests use DEB_CYCLES=4, SETTLE_CYCLES=3, ACTIVE_LOW=1.
- Reset: clr=1 for 2 cycles with b_raw=3'b111 -> all outputs 0. After release with no presses: no pulso/erro for 100 cycles, ocupado=0.
- b_raw=3'b101 (bit1 pressed) from before edge 10, held 20 cycles -> estavel=3'b010 after edge 15. Single pulso after edge 19 with pontos=2. ocupado high until 1 cycle after estavel returns to 0.
- bit0 low for 3 cycles only (glitch) -> estavel stays 0, no pulso, no erro.
- bit0 pressed, bit2 pressed 2 cycles later, both held -> exactly one erro, no pulso, pontos keeps prior value. Same with bit2 pressed 5 cycles later -> pulso with pontos=1, then no event for bit2 until all released.
- bit2 pressed, clr asserted 2 cycles into SETTLE, button held -> no pulso before/during clr. After clr drops, fresh debounce yields pulso with pontos=3 at the specified latency.
- With AUTO_REPEAT_EN, REPEAT_CYCLES=10: bit0 held 35 cycles past first pulso -> pulsos at +0, +10, +20, +30, all pontos=1. Without the macro: only the +0 pulse.
